// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller:
// op encoding, controller states, divider length and special results.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_MADD  = 4'd2,
      OP_MADDU = 4'd3,
      OP_DIV   = 4'd4,
      OP_DIVU  = 4'd5,
      OP_MTHI  = 4'd6,
      OP_MTLO  = 4'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } mdu_state_e;

   localparam int DIV_ITERS = 32;

   localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_A   = 32'h8000_0000;
   localparam logic [31:0] OVF_B   = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_LO  = 32'h8000_0000;
   localparam logic [31:0] OVF_HI  = 32'h0000_0000;

   // Magnitude of x, treating it as two's complement only when sgn is set.
   function automatic logic [31:0] mag(input logic [31:0] x,
                                       input logic        sgn);
      return (sgn && x[31]) ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// Ports: clear/load/step controls, dividend/divisor in, quotient/remainder out.
module mdu_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dvd_i,
   input  logic [31:0] dvs_i,
   output logic [31:0] quo_o,
   output logic [31:0] rem_o
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [32:0] sh_d;
   logic [32:0] diff_d;
   logic        ge_d;

   // Partial remainder stays below the divisor, so bit 32 of the
   // difference is a clean "shifted < divisor" flag.
   assign sh_d   = {rem_q, quo_q[31]};
   assign diff_d = sh_d - {1'b0, dvs_q};
   assign ge_d   = ~diff_d[32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (clear) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dvd_i;
         dvs_q <= dvs_i;
      end else if (step) begin
         rem_q <= ge_d ? diff_d[31:0] : sh_d[31:0];
         quo_q <= {quo_q[30:0], ge_d};
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner and multi-cycle MUL/DIV sequencer beside the EX-stage ALU.
// Ports: start/op/a/b request, flush, read_req; ready/busy/done, hi/lo, stall_read.
module hilo_mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   input  logic        read_req,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall_read
);

   mdu_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  op_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        is_mul;
   logic        is_div;
   logic        is_mthi;
   logic        is_mtlo;
   logic        div_load;
   logic        div_step;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   logic        msgn;
   logic        macc;
   logic [63:0] ea;
   logic [63:0] eb;
   logic [63:0] prod;
   logic [63:0] mul_d;

   logic        dsgn;
   logic        divz;
   logic        ovf;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [63:0] div_d;

   assign ready      = (state_q == S_IDLE);
   assign busy       = ~ready;
   assign done       = done_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign stall_read = read_req & busy;

   assign is_mul  = (op == OP_MULT) | (op == OP_MULTU) |
                    (op == OP_MADD) | (op == OP_MADDU);
   assign is_div  = (op == OP_DIV) | (op == OP_DIVU);
   assign is_mthi = (op == OP_MTHI);
   assign is_mtlo = (op == OP_MTLO);

   assign dvd_mag  = mag(a, op == OP_DIV);
   assign dvs_mag  = mag(b, op == OP_DIV);
   assign div_load = start & ready & ~flush & is_div;
   assign div_step = (state_q == S_DIV) & ~flush;

   mdu_divider u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .load  (div_load),
      .step  (div_step),
      .dvd_i (dvd_mag),
      .dvs_i (dvs_mag),
      .quo_o (quo),
      .rem_o (rem)
   );

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product
   // are then correct for both signednesses.
   assign msgn  = (op_q == OP_MULT) | (op_q == OP_MADD);
   assign macc  = (op_q == OP_MADD) | (op_q == OP_MADDU);
   assign ea    = msgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
   assign eb    = msgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
   assign prod  = ea * eb;
   assign mul_d = macc ? ({hi_q, lo_q} + prod) : prod;

   assign dsgn  = (op_q == OP_DIV);
   assign divz  = (b_q == 32'd0);
   assign ovf   = dsgn & (a_q == OVF_A) & (b_q == OVF_B);
   assign q_fix = (dsgn & (a_q[31] ^ b_q[31])) ? (~quo + 32'd1) : quo;
   assign r_fix = (dsgn & a_q[31]) ? (~rem + 32'd1) : rem;

   always_comb begin
      div_d = {r_fix, q_fix};
      unique case (1'b1)
         divz:    div_d = {a_q, DIVZ_LO};
         ovf:     div_d = {OVF_HI, OVF_LO};
         default: div_d = {r_fix, q_fix};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     a_q  <= a;
                     b_q  <= b;
                     op_q <= op;
                     unique case (1'b1)
                        is_mthi: hi_q <= a;
                        is_mtlo: lo_q <= a;
                        is_mul: begin
                           state_q <= S_MUL;
                           cnt_q   <= 5'(MUL_CYCLES - 1);
                        end
                        is_div: begin
                           state_q <= S_DIV;
                           cnt_q   <= 5'(DIV_ITERS - 1);
                        end
                        default: ;
                     endcase
                  end
               end
               S_MUL: begin
                  if (cnt_q == 5'd0) begin
                     {hi_q, lo_q} <= mul_d;
                     done_q       <= 1'b1;
                     state_q      <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 5'd1;
                  end
               end
               S_DIV: begin
                  if (cnt_q == 5'd0) begin
                     state_q <= S_FIX;
                  end else begin
                     cnt_q <= cnt_q - 5'd1;
                  end
               end
               S_FIX: begin
                  {hi_q, lo_q} <= div_d;
                  done_q       <= 1'b1;
                  state_q      <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: table of ops with a result
// scoreboard, plus hand sequences for busy, flush and reset corners.
module tb_hilo_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MC = 3;
   localparam int DL = 33;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        flush = 1'b0;
   logic        read_req = 1'b0;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_read;

   hilo_mdu_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .flush      (flush),
      .read_req   (read_req),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo),
      .stall_read (stall_read)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   vec_t tbl[17];
   exp_t sbq[$];
   int   ncmp = 0;
   int   nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; drives the op, then follows it to completion.
   task automatic run(input string nm, input logic [3:0] o,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el,
                      input int lat);
      exp_t e;
      int   n;
      e.hi = eh;
      e.lo = el;
      sbq.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      if (lat == 0) begin
         e = sbq.pop_front();
         chk({nm, " hi"}, {32'd0, hi}, {32'd0, e.hi});
         chk({nm, " lo"}, {32'd0, lo}, {32'd0, e.lo});
         chk({nm, " ready"}, {63'd0, ready}, 64'd1);
      end else begin
         n = 0;
         while (!done && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk({nm, " latency"}, 64'(n), 64'(lat));
         e = sbq.pop_front();
         chk({nm, " hilo"}, {hi, lo}, {e.hi, e.lo});
         chk({nm, " ready_in_done"}, {63'd0, ready}, 64'd1);
         @(negedge clk);
         chk({nm, " done_pulse"}, {63'd0, done}, 64'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int bad;
      int dn;

      tbl[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
      tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MC};
      tbl[2]  = '{OP_MTHI,  32'd0,        32'd9, 32'h00000000, 32'hFFFFFFFE, 0};
      tbl[3]  = '{OP_MTLO,  32'd5,        32'd9, 32'h00000000, 32'h00000005, 0};
      tbl[4]  = '{OP_MADD,  32'd3,        32'd4, 32'h00000000, 32'h00000011, MC};
      tbl[5]  = '{OP_MADDU, 32'hFFFFFFFF, 32'd1, 32'h00000001, 32'h00000010, MC};
      tbl[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DL};
      tbl[7]  = '{OP_DIVU,  32'd7,        32'd0, 32'h00000007, 32'hFFFFFFFF, DL};
      tbl[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000, DL};
      tbl[9]  = '{OP_DIVU,  32'd100,      32'd7, 32'h00000002, 32'h0000000E, DL};
      tbl[10] = '{OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DL};
      tbl[11] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,
                  32'h3FFFFFFF, 32'h00000001, MC};
      tbl[12] = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB,
                  32'h00000000, 32'h0000000F, MC};
      tbl[13] = '{OP_MADD,  32'hFFFFFFFF, 32'd1, 32'h00000000, 32'h0000000E, MC};
      tbl[14] = '{OP_DIV,   32'd0,        32'd0, 32'h00000000, 32'hFFFFFFFF, DL};
      tbl[15] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,
                  32'h00000005, 32'h19999999, DL};
      tbl[16] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9,
                  32'hFFFFFFFE, 32'h0000000E, DL};

      // Reset state
      #1 rst_n = 1'b0;
      read_req = 1'b1;
      #10;
      chk("rst hilo", {hi, lo}, 64'd0);
      chk("rst ready", {63'd0, ready}, 64'd1);
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst done", {63'd0, done}, 64'd0);
      chk("rst stall", {63'd0, stall_read}, 64'd0);
      read_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         run($sformatf("v%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo, tbl[i].lat);
      end

      // Busy: stall_read on every busy cycle, second start ignored.
      op = OP_MULTU; a = 32'd3; b = 32'd5; start = 1'b1; read_req = 1'b1;
      @(negedge clk);
      op = OP_MTHI; a = 32'hDEAD; start = 1'b1;
      n = 0;
      bad = 0;
      while (!done && n < 20) begin
         if (!stall_read) bad++;
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk("busy latency", 64'(n), 64'(MC));
      chk("busy stall_read", 64'(bad), 64'd0);
      chk("done no stall", {63'd0, stall_read}, 64'd0);
      chk("busy hilo", {hi, lo}, {32'd0, 32'd15});
      read_req = 1'b0;
      @(negedge clk);

      // Flush a divide in its tenth cycle, then MULT in the ready cycle.
      op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 9; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (done) dn++;
      chk("flush ready", {63'd0, ready}, 64'd1);
      chk("flush no_done", 64'(dn), 64'd0);
      chk("flush hilo", {hi, lo}, {32'd0, 32'd15});
      run("post_flush", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MC);

      // Flush on the commit edge suppresses the commit.
      op = OP_MULT; a = 32'd2; b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (MC - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("commit_flush done", {63'd0, done}, 64'd0);
      chk("commit_flush ready", {63'd0, ready}, 64'd1);
      chk("commit_flush hilo", {hi, lo}, {32'd0, 32'd42});

      // start together with flush is dropped.
      op = OP_MTLO; a = 32'h1234; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("start_flush lo", {32'd0, lo}, {32'd0, 32'd42});

      // Undefined op is a no-op.
      op = 4'hA; a = 32'h55; b = 32'h66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("undef ready", {63'd0, ready}, 64'd1);
      @(negedge clk);
      chk("undef done", {63'd0, done}, 64'd0);
      chk("undef hilo", {hi, lo}, {32'd0, 32'd42});

      // Asynchronous reset mid-MUL.
      op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst hilo", {hi, lo}, 64'd0);
      chk("arst ready", {63'd0, ready}, 64'd1);
      chk("arst done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the done cycle clears done at once.
      op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_done lo", {32'd0, lo}, {32'd0, 32'd9});
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done done", {63'd0, done}, 64'd0);
      chk("rst_done hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run("after_rst", OP_MULTU, 32'h10000, 32'h10000, 32'd1, 32'd0, MC);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

endmodule
